operand_sync: RTL and testbench
===============================

OPERAND_SYNC -- requirements
Module: operand_sync

Interface
REQ-001 The module SHALL have parameter `size`, default 32, giving the data width of every operand port.
REQ-002 The module SHALL have parameter `DEPTH`, default 4, giving entries per operand FIFO; it shall be a power of two, at least 2.
REQ-003 Port `clk`, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port `rst_n`, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port `config_sig`, input, 2 bits: mode select (0 join, 1 in0-only, 2 in1-only, 3 flush).
REQ-006 Port `in0`, input, `size` bits: operand-0 data.
REQ-007 Port `in0_valid`, input, 1 bit: `in0` holds valid data.
REQ-008 Port `in0_ready`, output, 1 bit: FIFO0 can accept data.
REQ-009 Port `in1`, input, `size` bits: operand-1 data.
REQ-010 Port `in1_valid`, input, 1 bit: `in1` holds valid data.
REQ-011 Port `in1_ready`, output, 1 bit: FIFO1 can accept data.
REQ-012 Port `out0`, output, `size` bits: operand 0 to the downstream ALU `in0`.
REQ-013 Port `out1`, output, `size` bits: operand 1 to the downstream ALU `in1`.
REQ-014 Port `out_valid`, output, 1 bit: `out0`/`out1` form a valid operand pair.
REQ-015 Port `out_ready`, input, 1 bit: the consumer accepts the pair.

Function
REQ-016 Two independent FIFOs SHALL be kept (FIFO0 for `in0`, FIFO1 for `in1`), each `DEPTH` entries.
- Each FIFO has read and write pointers that wrap modulo `DEPTH`.
- Each FIFO has an occupancy counter of width clog2(DEPTH)+1.
REQ-017 Readiness: `inN_ready` SHALL be high exactly when FIFO N is not full and `config_sig` is not 3.
REQ-018 Push: FIFO N SHALL write `inN` at the rising edge where `inN_valid` and `inN_ready` are both high.
REQ-019 Output data: `out0`/`out1` SHALL show the head entries of FIFO0/FIFO1 combinationally (first-word fall-through).
- In mode 2, `out0` is forced to 0.
- In mode 1, `out1` is forced to 0.
REQ-020 `out_valid` SHALL be:
- mode 0: FIFO0 non-empty AND FIFO1 non-empty;
- mode 1: FIFO0 non-empty;
- mode 2: FIFO1 non-empty;
- mode 3: 0.
REQ-021 Pop: at an edge where `out_valid` and `out_ready` are both high, the FIFOs used by the current mode SHALL pop one entry each.
- Mode 0 pops both FIFOs.
- Modes 1 and 2 pop only the selected FIFO; the other keeps its contents.
REQ-022 Latency: data pushed at edge k SHALL first be visible at the output after edge k; there is no same-cycle bypass into an empty FIFO.
REQ-023 Full: a full FIFO SHALL deassert ready even when a pop happens in the same cycle; no write-through.
REQ-024 Simultaneous push and pop on a non-full, non-empty FIFO SHALL leave its occupancy unchanged and advance both pointers.
REQ-025 Pairing: in mode 0, entries SHALL pair strictly in arrival order per FIFO; the i-th `in0` accepted pairs with the i-th `in1` accepted.
REQ-026 Flush (mode 3): at each edge, both FIFOs SHALL reset pointers and occupancy to 0, discarding their contents.
REQ-027 Mode change: a change among modes 0-2 SHALL take effect combinationally in the same cycle and SHALL keep FIFO contents.
REQ-028 `out_valid` SHALL NOT depend combinationally on `out_ready`.

Reset
REQ-029 While `rst_n`=0, independent of `clk`: all pointers and occupancy counters SHALL be 0, `out_valid`=0 and `in0_ready`=`in1_ready`=1 (unless mode 3).
REQ-030 Reset asserted mid-operation SHALL discard all stored entries immediately; the FIFO RAM contents need no reset.
REQ-031 After `rst_n` deasserts, the first push SHALL be accepted at the next rising edge.

Verification
REQ-032 Join: mode 0; push in0=5 then in1=7 one cycle later; `out_ready`=1 -> `out_valid` rises after the in1 edge with out0=5, out1=7; both FIFOs are empty next cycle.
REQ-033 Backpressure/full: mode 0, `DEPTH`=4, `out_ready`=0; push 5 values on in0 -> 4 accepted, `in0_ready`=0 after the 4th; `out_valid`=0 until in1 is pushed.
REQ-034 Order and wrap: mode 0; stream 10 pairs (i, 100+i) with random valids and random `out_ready` -> outputs are (0,100)...(9,109) in order, with no loss or duplication.
REQ-035 Single-operand mode: mode 1; FIFO1 holds 2 entries; push in0=3 -> out0=3, out1=0, `out_valid`=1; pop; switch to mode 0 -> FIFO1 still holds 2 entries.
REQ-036 Flush and reset: fill both FIFOs with 3 entries, set mode 3 for one cycle, return to mode 0 -> `out_valid`=0 and both FIFOs are empty; repeat with `rst_n` pulsed low between clock edges -> the same result, taking effect asynchronously.

Source files
------------

// File: rtl/operand_sync.sv
// Operand synchronizer: two first-word-fall-through FIFOs that join in0/in1
// into operand pairs for a downstream ALU, with single-operand and flush modes.
module operand_sync #(
  parameter int size  = 32,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      config_sig,
  input  logic [size-1:0] in0,
  input  logic            in0_valid,
  output logic            in0_ready,
  input  logic [size-1:0] in1,
  input  logic            in1_valid,
  output logic            in1_ready,
  output logic [size-1:0] out0,
  output logic [size-1:0] out1,
  output logic            out_valid,
  input  logic            out_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  typedef enum logic [1:0] {
    MODE_JOIN  = 2'd0,
    MODE_IN0   = 2'd1,
    MODE_IN1   = 2'd2,
    MODE_FLUSH = 2'd3
  } mode_e;

  mode_e           mode;
  logic            flush;
  logic [size-1:0] din  [2];
  logic [size-1:0] head [2];
  logic [1:0]      din_valid;
  logic [1:0]      ready;
  logic [1:0]      empty;
  logic [1:0]      push;
  logic [1:0]      pop;
  logic [1:0]      uses;

  assign mode      = mode_e'(config_sig);
  assign flush     = (mode == MODE_FLUSH);
  assign din[0]    = in0;
  assign din[1]    = in1;
  assign din_valid = {in1_valid, in0_valid};

  // NOTE: every output of this block gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    out_valid = 1'b0;
    uses      = 2'b00;
    unique case (mode)
      MODE_JOIN: begin
        uses      = 2'b11;
        out_valid = !empty[0] && !empty[1];
      end
      MODE_IN0: begin
        uses      = 2'b01;
        out_valid = !empty[0];
      end
      MODE_IN1: begin
        uses      = 2'b10;
        out_valid = !empty[1];
      end
      default: ;
    endcase
  end

  // Ready is derived from occupancy only, so a full FIFO never accepts even while popping.
  assign push = din_valid & ready;
  assign pop  = uses & {2{out_valid && out_ready}};

  for (genvar g = 0; g < 2; g++) begin : g_fifo
    logic [size-1:0] mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;

    assign empty[g] = (count == '0);
    assign ready[g] = (count != FULL_CNT) && !flush;
    assign head[g]  = mem[rd_ptr];

    // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push[g]) wr_ptr <= wr_ptr + PTR_ONE;
        if (pop[g])  rd_ptr <= rd_ptr + PTR_ONE;
        unique case ({push[g], pop[g]})
          2'b10:   count <= count + CNT_ONE;
          2'b01:   count <= count - CNT_ONE;
          default: ;
        endcase
      end
    end

    // NOTE: storage has no reset; the occupancy counter alone decides which entries are live.
    always_ff @(posedge clk) begin
      if (push[g]) mem[wr_ptr] <= din[g];
    end
  end

  assign in0_ready = ready[0];
  assign in1_ready = ready[1];
  assign out0      = (mode == MODE_IN1) ? '0 : head[0];
  assign out1      = (mode == MODE_IN0) ? '0 : head[1];

endmodule

// File: tb/tb_operand_sync.sv
// Self-checking bench for operand_sync: directed table, hand-written corner
// sequences, and randomized traffic against a queue-based reference model.
module tb_operand_sync;
  localparam int W     = 32;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [1:0]   config_sig = 2'd0;
  logic [W-1:0] in0 = '0;
  logic         in0_valid = 1'b0;
  logic         in0_ready;
  logic [W-1:0] in1 = '0;
  logic         in1_valid = 1'b0;
  logic         in1_ready;
  logic [W-1:0] out0;
  logic [W-1:0] out1;
  logic         out_valid;
  logic         out_ready = 1'b0;

  operand_sync #(.size(W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .config_sig(config_sig),
    .in0       (in0),
    .in0_valid (in0_valid),
    .in0_ready (in0_ready),
    .in1       (in1),
    .in1_valid (in1_valid),
    .in1_ready (in1_ready),
    .out0      (out0),
    .out1      (out1),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: each FIFO is a plain queue of accepted words.
  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];

  typedef struct {
    logic [1:0]   cfg;
    logic         v0;
    logic [W-1:0] d0;
    logic         v1;
    logic [W-1:0] d1;
    logic         ordy;
    logic         r0;
    logic         r1;
    logic         ov;
    logic         chk0;
    logic [W-1:0] o0;
    logic         chk1;
    logic [W-1:0] o1;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic m_valid(input logic [1:0] m);
    case (m)
      2'd0:    return (q0.size() > 0) && (q1.size() > 0);
      2'd1:    return q0.size() > 0;
      2'd2:    return q1.size() > 0;
      default: return 1'b0;
    endcase
  endfunction

  task automatic drive(input logic [1:0] cfg, input logic v0, input logic [W-1:0] d0,
                       input logic v1, input logic [W-1:0] d1, input logic ordy);
    config_sig = cfg;
    in0_valid  = v0;
    in0        = d0;
    in1_valid  = v1;
    in1        = d1;
    out_ready  = ordy;
  endtask

  task automatic check_model();
    check("in0_ready", in0_ready, (q0.size() < DEPTH) && (config_sig != 2'd3));
    check("in1_ready", in1_ready, (q1.size() < DEPTH) && (config_sig != 2'd3));
    check("out_valid", out_valid, m_valid(config_sig));
    if (config_sig == 2'd2) check("out0_forced", out0, 0);
    else if (q0.size() > 0) check("out0_head", out0, q0[0]);
    if (config_sig == 2'd1) check("out1_forced", out1, 0);
    else if (q1.size() > 0) check("out1_head", out1, q1[0]);
  endtask

  // Advance one clock edge and apply the same edge to the model.
  task automatic tick();
    logic [1:0]   m;
    logic         p0, p1, pp0, pp1;
    logic [W-1:0] d0, d1;
    m   = config_sig;
    d0  = in0;
    d1  = in1;
    p0  = in0_valid && (q0.size() < DEPTH) && (m != 2'd3);
    p1  = in1_valid && (q1.size() < DEPTH) && (m != 2'd3);
    pp0 = m_valid(m) && out_ready && (m == 2'd0 || m == 2'd1);
    pp1 = m_valid(m) && out_ready && (m == 2'd0 || m == 2'd2);
    @(posedge clk);
    if (m == 2'd3) begin
      q0.delete();
      q1.delete();
    end else begin
      if (pp0) q0.delete(0);
      if (pp1) q1.delete(0);
      if (p0)  q0.push_back(d0);
      if (p1)  q1.push_back(d1);
    end
    #1;
  endtask

  initial begin
    //         cfg  v0 d0  v1 d1  rdy  r0 r1 ov  c0 o0  c1 o1
    vecs[0]  = '{2'd0, 1, 5,  0, 0,  1,  1, 1, 0,  0, 0,  0, 0};
    vecs[1]  = '{2'd0, 0, 0,  1, 7,  1,  1, 1, 0,  1, 5,  0, 0};
    vecs[2]  = '{2'd0, 0, 0,  0, 0,  1,  1, 1, 1,  1, 5,  1, 7};
    vecs[3]  = '{2'd0, 0, 0,  0, 0,  1,  1, 1, 0,  0, 0,  0, 0};
    vecs[4]  = '{2'd0, 1, 11, 0, 0,  0,  1, 1, 0,  0, 0,  0, 0};
    vecs[5]  = '{2'd0, 1, 12, 0, 0,  0,  1, 1, 0,  1, 11, 0, 0};
    vecs[6]  = '{2'd0, 1, 13, 0, 0,  0,  1, 1, 0,  1, 11, 0, 0};
    vecs[7]  = '{2'd0, 1, 14, 0, 0,  0,  1, 1, 0,  1, 11, 0, 0};
    vecs[8]  = '{2'd0, 1, 15, 0, 0,  0,  0, 1, 0,  1, 11, 0, 0};
    vecs[9]  = '{2'd0, 0, 0,  1, 21, 0,  0, 1, 0,  1, 11, 0, 0};
    vecs[10] = '{2'd0, 0, 0,  0, 0,  1,  0, 1, 1,  1, 11, 1, 21};
    vecs[11] = '{2'd0, 1, 99, 0, 0,  0,  1, 1, 0,  1, 12, 0, 0};
    vecs[12] = '{2'd0, 0, 0,  1, 22, 0,  0, 1, 0,  1, 12, 0, 0};
    vecs[13] = '{2'd0, 1, 50, 0, 0,  1,  0, 1, 1,  1, 12, 1, 22};
    vecs[14] = '{2'd1, 0, 0,  0, 0,  0,  1, 1, 1,  1, 13, 1, 0};
    vecs[15] = '{2'd2, 0, 0,  0, 0,  0,  1, 1, 0,  1, 0,  0, 0};
    vecs[16] = '{2'd3, 0, 0,  0, 0,  0,  0, 0, 0,  0, 0,  0, 0};
    vecs[17] = '{2'd0, 0, 0,  0, 0,  0,  1, 1, 0,  0, 0,  0, 0};

    // Reset state, checked before any clock edge is allowed to matter.
    drive(2'd0, 0, 0, 0, 0, 1);
    #2;
    check("rst_in0_ready", in0_ready, 1);
    check("rst_in1_ready", in1_ready, 1);
    check("rst_out_valid", out_valid, 0);
    config_sig = 2'd3;
    #1;
    check("rst_flush_ready", in0_ready, 0);
    config_sig = 2'd0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table: join, full/backpressure, full-with-pop, modes, flush.
    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].cfg, vecs[i].v0, vecs[i].d0, vecs[i].v1, vecs[i].d1, vecs[i].ordy);
      #1;
      check($sformatf("vec%0d_in0_ready", i), in0_ready, vecs[i].r0);
      check($sformatf("vec%0d_in1_ready", i), in1_ready, vecs[i].r1);
      check($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].ov);
      if (vecs[i].chk0) check($sformatf("vec%0d_out0", i), out0, vecs[i].o0);
      if (vecs[i].chk1) check($sformatf("vec%0d_out1", i), out1, vecs[i].o1);
      tick();
    end
    drive(2'd0, 0, 0, 0, 0, 0);
    #1 check_model();

    // Single-operand mode leaves FIFO1 untouched.
    drive(2'd0, 0, 0, 1, 31, 0); tick();
    drive(2'd0, 0, 0, 1, 32, 0); tick();
    drive(2'd1, 1, 3, 0, 0, 0);  #1 check_model(); tick();
    drive(2'd1, 0, 0, 0, 0, 0);
    #1;
    check("m1_valid", out_valid, 1);
    check("m1_out0", out0, 3);
    check("m1_out1", out1, 0);
    out_ready = 1'b1;
    #1 tick();
    drive(2'd0, 1, 8, 0, 0, 0);
    #1;
    check("m0_empty0_valid", out_valid, 0);
    check("m0_kept_out1", out1, 31);
    tick();
    drive(2'd0, 0, 0, 0, 0, 1);
    #1;
    check("m0_pair_a_valid", out_valid, 1);
    check("m0_pair_a_out0", out0, 8);
    check("m0_pair_a_out1", out1, 31);
    tick();
    drive(2'd0, 1, 9, 0, 0, 1);
    #1;
    check("m0_second_valid", out_valid, 0);
    check("m0_second_out1", out1, 32);
    tick();
    drive(2'd0, 0, 0, 0, 0, 1);
    #1;
    check("m0_pair_b_out0", out0, 9);
    check("m0_pair_b_out1", out1, 32);
    tick();
    drive(2'd0, 0, 0, 0, 0, 0);
    #1 check_model();

    // Flush for one cycle, then asynchronous reset between edges.
    for (int i = 0; i < 3; i++) begin
      drive(2'd0, 1, W'(40 + i), 1, W'(60 + i), 0);
      tick();
    end
    drive(2'd0, 0, 0, 0, 0, 0);
    #1 check("fill_valid", out_valid, 1);
    drive(2'd3, 0, 0, 0, 0, 0);
    #1 check_model();
    tick();
    drive(2'd0, 0, 0, 0, 0, 0);
    #1;
    check("flush_valid", out_valid, 0);
    check_model();
    for (int i = 0; i < 3; i++) begin
      drive(2'd0, 1, W'(70 + i), 1, W'(80 + i), 0);
      tick();
    end
    drive(2'd0, 0, 0, 0, 0, 0);
    #1 check("refill_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_in0_ready", in0_ready, 1);
    check("arst_in1_ready", in1_ready, 1);
    q0.delete();
    q1.delete();
    #1 rst_n = 1'b1;
    drive(2'd0, 1, 77, 1, 78, 0);
    #1 check_model();
    tick();
    drive(2'd0, 0, 0, 0, 0, 0);
    #1;
    check("post_rst_valid", out_valid, 1);
    check("post_rst_out0", out0, 77);
    check("post_rst_out1", out1, 78);
    drive(2'd0, 0, 0, 0, 0, 1);
    #1 tick();

    // Ordered stream of 10 pairs under random valids and backpressure.
    begin
      int n0 = 0;
      int n1 = 0;
      int got = 0;
      int cyc = 0;
      while (got < 10 && cyc < 500) begin
        config_sig = 2'd0;
        in0_valid  = (n0 < 10) && ($urandom_range(0, 1) == 1);
        in0        = W'(n0);
        in1_valid  = (n1 < 10) && ($urandom_range(0, 1) == 1);
        in1        = W'(100 + n1);
        out_ready  = ($urandom_range(0, 1) == 1);
        #1;
        check_model();
        if (out_valid && out_ready) begin
          check("stream_out0", out0, got);
          check("stream_out1", out1, 100 + got);
          got++;
        end
        if (in0_valid && in0_ready) n0++;
        if (in1_valid && in1_ready) n1++;
        tick();
        cyc++;
      end
      check("stream_pairs", got, 10);
      drive(2'd0, 0, 0, 0, 0, 1);
      #1 check_model();
    end

    // Random modes and data against the queue model.
    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(0, 19);
      config_sig = (r == 0) ? 2'd3 : 2'(r % 3);
      in0_valid  = ($urandom_range(0, 1) == 1);
      in0        = $urandom;
      in1_valid  = ($urandom_range(0, 1) == 1);
      in1        = $urandom;
      out_ready  = ($urandom_range(0, 2) != 0);
      #1 check_model();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
